ahb_sram: RTL and testbench
===========================

AHB_SRAM -- requirements
Module: ahb_sram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, bus data width in bits; legal values are 32 and 64.
REQ-002 SHALL have parameter MEM_BYTES, default 1024, storage size in bytes; a power of two that is at least DATA_WIDTH/8.
REQ-003 SHALL have parameter BASE_ADDR, default 64'h0, first byte address decoded; aligned to MEM_BYTES.
REQ-004 SHALL have parameter WAIT_STATES, default 0, extra data-phase cycles per OKAY transfer; range 0..15.
REQ-005 SHALL have port HCLK, input, 1 bit, the only clock, rising edge.
REQ-006 SHALL have port HRESETn, input, 1 bit, reset; asynchronous assert, active-low.
REQ-007 SHALL have port HSEL, input, 1 bit, slave select.
REQ-008 SHALL have port HADDR, input, 64 bits, byte address.
REQ-009 SHALL have port HTRANS, input, 2 bits: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
REQ-010 SHALL have port HWRITE, input, 1 bit: 1=write, 0=read.
REQ-011 SHALL have port HSIZE, input, 3 bits, transfer size 0..3 (byte..dword).
REQ-012 SHALL have port HWDATA, input, DATA_WIDTH bits, write data, valid in the data phase.
REQ-013 SHALL have port HREADY, input, 1 bit, bus-level ready.
REQ-014 SHALL have port HREADYOUT, output, 1 bit, slave ready.
REQ-015 SHALL have port HRESP, output, 1 bit: 0=OKAY, 1=ERROR.
REQ-016 SHALL have port HRDATA, output, DATA_WIDTH bits, read data.

Function
REQ-017 SHALL sample an address phase on the rising HCLK edge when HSEL=1, HTRANS[1]=1 and HREADY=1; it SHALL latch HADDR, HWRITE and HSIZE.
REQ-018 SHALL treat IDLE/BUSY, and HSEL=0, as no transfer: zero-wait OKAY, no storage change.
REQ-019 SHALL flag a latched transfer as error if the address is outside [BASE_ADDR, BASE_ADDR+MEM_BYTES-1], if HSIZE is unaligned (HADDR mod 2^HSIZE != 0), or if 2^HSIZE > DATA_WIDTH/8.
REQ-020 SHALL use FSM states IDLE, WAIT, ERR1, ERR2.
REQ-021 From IDLE, an OKAY transfer SHALL go to WAIT with counter=WAIT_STATES, or complete in the next cycle if WAIT_STATES=0.
REQ-022 From IDLE, an error transfer SHALL go to ERR1.
REQ-023 In WAIT, HREADYOUT=0 and the counter SHALL decrement each cycle; at 0, HREADYOUT=1 and the transfer completes.
REQ-024 ERR1 SHALL drive HREADYOUT=0, HRESP=1; ERR2 SHALL drive HREADYOUT=1, HRESP=1; then IDLE, or accept a new address phase if one is present.
REQ-025 Error transfers SHALL NOT modify storage; HRDATA SHALL be 0 during them.
REQ-026 A write SHALL commit on the completing edge (HREADYOUT=1), only the byte lanes selected by HSIZE and HADDR[log2(DATA_WIDTH/8)-1:0]; other bytes unchanged.
REQ-027 Read data SHALL be driven on HRDATA during the completing cycle as the full aligned word; unselected lanes carry stored contents.
REQ-028 HRDATA SHALL hold its last value outside read completion.
REQ-029 A read whose address phase coincides with the completing cycle of a write to the same word SHALL return the newly written bytes (no stale data).
REQ-030 A new address phase SHALL be accepted in the completing cycle of the previous transfer (back-to-back pipelining); throughput is 1 transfer per (1+WAIT_STATES) cycles.
REQ-031 Byte ordering SHALL be little-endian: lane k holds byte address (word base + k).
REQ-032 Internal storage address SHALL be (HADDR-BASE_ADDR) truncated to log2(MEM_BYTES) bits; no wrap beyond MEM_BYTES (out-of-range errors instead).

Reset
REQ-033 HRESETn low SHALL asynchronously force FSM=IDLE, counter=0, HREADYOUT=1, HRESP=0, HRDATA=0 and clear the latched address phase.
REQ-034 Reset during WAIT or ERR1/ERR2 SHALL abandon the transfer with no storage write.
REQ-035 Storage contents SHALL NOT be reset.

Structure
REQ-036 Shared package ahb_pkg SHALL hold HTRANS and HSIZE encodings, the HRESP codes and the FSM state typedef.
REQ-037 Byte-lane enable generation (HSIZE, low address bits -> DATA_WIDTH/8 mask) SHALL be sub-module ahb_lane_mask.

Verification
REQ-038 DW=32, WS=0: write 32'hDEADBEEF @0x10 (HSIZE=2), then read @0x10 -> HRDATA=32'hDEADBEEF, HREADYOUT never low, HRESP=0.
REQ-039 Byte write 8'hA5 @0x13 (HSIZE=0) over 32'hDEADBEEF -> read @0x10 returns 32'hA5ADBEEF.
REQ-040 WS=3: read @0x20 -> HREADYOUT low exactly 3 cycles, then data with HRESP=0.
REQ-041 Read @BASE_ADDR+MEM_BYTES, and halfword @0x11 -> HREADYOUT=0/HRESP=1, then HREADYOUT=1/HRESP=1, storage unchanged.
REQ-042 Back-to-back write 0x12345678 @0x0 then read @0x0 pipelined -> read returns 0x12345678 in its first data cycle.
REQ-043 Assert HRESETn low in WAIT of a write -> outputs at reset values immediately, target word keeps its old value.

Source files
------------

// File: rtl/ahb_pkg.sv
// AHB-Lite encodings shared by the SRAM slave and its helpers.
// Also holds the slave's data-phase state type.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'd0;
  localparam logic [1:0] HTRANS_BUSY   = 2'd1;
  localparam logic [1:0] HTRANS_NONSEQ = 2'd2;
  localparam logic [1:0] HTRANS_SEQ    = 2'd3;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_WAIT = 2'd1;
  localparam state_t ST_ERR1 = 2'd2;
  localparam state_t ST_ERR2 = 2'd3;

  function automatic logic is_transfer(input logic [1:0] htrans);
    return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ahb_lane_mask.sv
// Byte-lane enables for a transfer of 2^size bytes at the given low address bits.
// A lane is selected when it falls in the same size-aligned block as the address.
module ahb_lane_mask #(
  parameter int BYTES = 4,
  parameter int LB    = $clog2(BYTES)
) (
  input  logic [2:0]       size,
  input  logic [LB-1:0]    addr_lo,
  output logic [BYTES-1:0] mask
);

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      localparam logic [LB-1:0] LANE = LB'(gi);
      assign mask[gi] = ((LANE >> size) == (addr_lo >> size));
    end
  endgenerate

endmodule

// File: rtl/ahb_sram.sv
// AHB-Lite SRAM slave: pipelined address/data phases, configurable wait states,
// two-cycle ERROR response, little-endian byte-lane writes with write->read forwarding.
module ahb_sram
  import ahb_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          MEM_BYTES   = 1024,
  parameter logic [63:0] BASE_ADDR   = 64'h0,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [63:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [DATA_WIDTH-1:0] HRDATA
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int LB    = $clog2(BYTES);
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int WORDS = MEM_BYTES / BYTES;
  localparam int IW    = (AW > LB) ? AW - LB : 1;
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  logic [DATA_WIDTH-1:0] mem [0:WORDS-1];

  state_t         state_reg;
  logic [3:0]     cnt_reg;
  logic           lat_write_reg;
  logic [2:0]     lat_size_reg;
  logic [LB-1:0]  lat_lo_reg;
  logic [IW-1:0]  lat_idx_reg;

  logic [63:0]           off;
  logic                  in_range;
  logic                  misaligned;
  logic                  too_wide;
  logic                  addr_err;
  logic                  accept;
  logic [IW-1:0]         a_idx;
  logic                  complete;
  logic                  wr_commit;
  logic                  load_now;
  logic                  load_late;
  logic [BYTES-1:0]      mask;
  logic [IW-1:0]         rd_idx;
  logic [DATA_WIDTH-1:0] rd_word;

  // Base is aligned to MEM_BYTES, so any address below it wraps to a huge offset.
  assign off      = HADDR - BASE_ADDR;
  assign in_range = ((off >> AW) == 64'd0);
  assign a_idx    = off[LB +: IW];
  assign too_wide = (HSIZE > 3'(LB));

  always_comb begin
    case (HSIZE)
      HSIZE_BYTE: misaligned = 1'b0;
      HSIZE_HALF: misaligned = HADDR[0];
      HSIZE_WORD: misaligned = |HADDR[1:0];
      default:    misaligned = |HADDR[2:0];
    endcase
  end

  assign addr_err = !in_range || misaligned || too_wide;

  assign HREADYOUT = !((state_reg == ST_WAIT && cnt_reg != 4'd0) || state_reg == ST_ERR1);
  assign HRESP     = (state_reg == ST_ERR1 || state_reg == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;

  assign accept    = HSEL && is_transfer(HTRANS) && HREADY && HREADYOUT;
  assign complete  = (state_reg == ST_WAIT) && (cnt_reg == 4'd0);
  assign wr_commit = complete && lat_write_reg;

  ahb_lane_mask #(
    .BYTES (BYTES),
    .LB    (LB)
  ) u_lane_mask (
    .size    (lat_size_reg),
    .addr_lo (lat_lo_reg),
    .mask    (mask)
  );

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= 4'd0;
      lat_write_reg <= 1'b0;
      lat_size_reg  <= 3'd0;
      lat_lo_reg    <= '0;
      lat_idx_reg   <= '0;
    end else if (accept) begin
      lat_write_reg <= HWRITE;
      lat_size_reg  <= HSIZE;
      lat_lo_reg    <= HADDR[LB-1:0];
      lat_idx_reg   <= a_idx;
      state_reg     <= addr_err ? ST_ERR1 : ST_WAIT;
      cnt_reg       <= addr_err ? 4'd0 : WS;
    end else begin
      case (state_reg)
        ST_WAIT: begin
          if (cnt_reg != 4'd0) cnt_reg <= cnt_reg - 4'd1;
          else                 state_reg <= ST_IDLE;
        end
        ST_ERR1: state_reg <= ST_ERR2;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK) begin
    if (wr_commit) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mask[b]) mem[lat_idx_reg][b*8 +: 8] <= HWDATA[b*8 +: 8];
      end
    end
  end

  // A zero-wait read issued while a write completes sees that write's bytes.
  always_comb begin
    rd_idx  = accept ? a_idx : lat_idx_reg;
    rd_word = mem[rd_idx];
    if (wr_commit && rd_idx == lat_idx_reg) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mask[b]) rd_word[b*8 +: 8] = HWDATA[b*8 +: 8];
      end
    end
  end

  assign load_now  = accept && !addr_err && !HWRITE && (WS == 4'd0);
  assign load_late = (state_reg == ST_WAIT) && (cnt_reg == 4'd1) && !lat_write_reg;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      HRDATA <= '0;
    end else if (accept && addr_err) begin
      HRDATA <= '0;
    end else if (load_now || load_late) begin
      HRDATA <= rd_word;
    end
  end

endmodule

// File: tb/tb_ahb_sram.sv
// Directed bench for ahb_sram: a zero-wait and a three-wait instance share one bus,
// a byte-level model predicts every output cycle, plus literal spot checks.
module tb_ahb_sram;

  typedef struct {
    logic        rdy;
    logic        resp;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        sel0, sel1;
  logic [63:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        rdy0, resp0, rdy1, resp1;
  logic [31:0] rd0, rd1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  ahb_sram #(.DATA_WIDTH(32), .MEM_BYTES(1024), .BASE_ADDR(64'h0), .WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rd0)
  );

  ahb_sram #(.DATA_WIDTH(32), .MEM_BYTES(1024), .BASE_ADDR(64'h0), .WAIT_STATES(3)) dut1 (
    .HCLK(clk), .HRESETn(rst_n), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(rdy1),
    .HREADYOUT(rdy1), .HRESP(resp1), .HRDATA(rd1)
  );

  logic [7:0]  mm [0:1][0:1023];
  logic [31:0] cur_rd [0:1];
  logic [31:0] last_rd [0:1];
  exp_t        q0[$];
  exp_t        q1[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  bit          chk_en  = 1'b0;

  function automatic exp_t mk(input logic r, input logic e, input logic [31:0] d);
    exp_t x;
    x.rdy  = r;
    x.resp = e;
    x.rd   = d;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, got, want);
    end
  endtask

  task automatic push_exp(input int d, input exp_t x);
    if (d == 0) q0.push_back(x);
    else        q1.push_back(x);
  endtask

  // Predicts the data-phase outputs of one transfer and updates the byte store.
  task automatic model(input int d, input bit wr, input bit [2:0] sz, input bit [63:0] a,
                       input bit [31:0] wd, output int ncyc);
    longint unsigned nb;
    int ws;
    bit err;
    int ai;
    int base;
    nb  = 64'd1 << sz;
    ws  = (d == 0) ? 0 : 3;
    err = (a >= 64'd1024) || ((a % nb) != 0) || (nb > 4);
    if (err) begin
      cur_rd[d] = 32'h0;
      push_exp(d, mk(1'b0, 1'b1, 32'h0));
      push_exp(d, mk(1'b1, 1'b1, 32'h0));
      ncyc = 2;
    end else begin
      ai = int'(a);
      for (int i = 0; i < ws; i++) push_exp(d, mk(1'b0, 1'b0, cur_rd[d]));
      if (wr) begin
        for (int i = 0; i < int'(nb); i++) mm[d][ai+i] = wd[8*((ai+i)%4) +: 8];
      end else begin
        base = ai - (ai % 4);
        cur_rd[d] = {mm[d][base+3], mm[d][base+2], mm[d][base+1], mm[d][base]};
      end
      push_exp(d, mk(1'b1, 1'b0, cur_rd[d]));
      ncyc = ws + 1;
    end
  endtask

  // One address phase; returns #1 into the transfer's last data cycle.
  task automatic xfer(input int d, input bit wr, input bit [2:0] sz, input bit [63:0] a,
                      input bit [31:0] wd);
    int n;
    sel0   = (d == 0);
    sel1   = (d == 1);
    htrans = 2'b10;
    haddr  = a;
    hwrite = wr;
    hsize  = sz;
    @(posedge clk);
    model(d, wr, sz, a, wd, n);
    #1;
    sel0   = 1'b0;
    sel1   = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
    repeat (n - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle();
    sel0   = 1'b0;
    sel1   = 1'b0;
    htrans = 2'b00;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      exp_t e0, e1;
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        last_rd[0] = e0.rd;
      end else begin
        e0 = mk(1'b1, 1'b0, last_rd[0]);
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        last_rd[1] = e1.rd;
      end else begin
        e1 = mk(1'b1, 1'b0, last_rd[1]);
      end
      chk("ws0_bus{rdy,resp,rdata}", 64'({rdy0, resp0, rd0}), 64'({e0.rdy, e0.resp, e0.rd}));
      chk("ws3_bus{rdy,resp,rdata}", 64'({rdy1, resp1, rd1}), 64'({e1.rdy, e1.resp, e1.rd}));
    end
  end

  initial begin
    rst_n  = 1'b0;
    sel0   = 1'b0;
    sel1   = 1'b0;
    haddr  = 64'h0;
    htrans = 2'b00;
    hwrite = 1'b0;
    hsize  = 3'd0;
    hwdata = 32'h0;
    for (int d = 0; d < 2; d++) begin
      cur_rd[d]  = 32'h0;
      last_rd[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ws0", 64'({rdy0, resp0, rd0}), 64'({1'b1, 1'b0, 32'h0}));
    chk("reset_ws3", 64'({rdy1, resp1, rd1}), 64'({1'b1, 1'b0, 32'h0}));
    rst_n  = 1'b1;
    chk_en = 1'b1;

    // Zero-wait instance
    xfer(0, 1, 3'd2, 64'h10, 32'hDEADBEEF); idle();
    xfer(0, 0, 3'd2, 64'h10, 32'h0);
    chk("lit_word_read", 64'(rd0), 64'h0000_0000_DEAD_BEEF);
    idle();
    xfer(0, 1, 3'd0, 64'h13, 32'hA500_0000); idle();
    xfer(0, 0, 3'd2, 64'h10, 32'h0);
    chk("lit_byte_merge", 64'(rd0), 64'h0000_0000_A5AD_BEEF);
    idle();
    xfer(0, 0, 3'd2, 64'h400, 32'h0); idle();
    xfer(0, 1, 3'd1, 64'h11, 32'hFFFF_FFFF); idle();
    // Deselected NONSEQ and a selected BUSY must not touch storage.
    haddr = 64'h10; hwrite = 1'b1; hsize = 3'd2; htrans = 2'b10; sel0 = 1'b0;
    @(posedge clk); #1;
    hwdata = 32'h0BAD_0BAD; htrans = 2'b01; sel0 = 1'b1;
    @(posedge clk); #1;
    idle();
    xfer(0, 0, 3'd2, 64'h10, 32'h0);
    chk("lit_err_no_write", 64'(rd0), 64'h0000_0000_A5AD_BEEF);
    idle();
    xfer(0, 1, 3'd2, 64'h0, 32'h1234_5678);
    xfer(0, 0, 3'd2, 64'h0, 32'h0);
    chk("lit_pipelined_fwd", 64'(rd0), 64'h0000_0000_1234_5678);
    idle();
    xfer(0, 1, 3'd1, 64'h2, 32'hCAFE_0000);
    xfer(0, 0, 3'd0, 64'h1, 32'h0);
    chk("lit_half_fwd", 64'(rd0), 64'h0000_0000_CAFE_5678);
    idle();
    xfer(0, 0, 3'd3, 64'h8, 32'h0); idle();
    xfer(0, 1, 3'd2, 64'h3FC, 32'h0BAD_F00D); idle();
    xfer(0, 0, 3'd2, 64'h3FC, 32'h0);
    chk("lit_top_word", 64'(rd0), 64'h0000_0000_0BAD_F00D);
    idle();

    // Three-wait instance
    xfer(1, 1, 3'd2, 64'h20, 32'h55AA_33CC); idle();
    xfer(1, 0, 3'd2, 64'h20, 32'h0);
    chk("lit_ws3_read", 64'(rd1), 64'h0000_0000_55AA_33CC);
    idle();
    xfer(1, 0, 3'd2, 64'h22, 32'h0); idle();
    xfer(1, 1, 3'd2, 64'h24, 32'h0F0F_1234);
    xfer(1, 0, 3'd2, 64'h24, 32'h0);
    chk("lit_ws3_pipelined", 64'(rd1), 64'h0000_0000_0F0F_1234);
    idle();
    xfer(1, 1, 3'd2, 64'h40, 32'h1111_2222); idle();

    // Reset in the middle of a waited write
    chk_en = 1'b0;
    sel1 = 1'b1; htrans = 2'b10; haddr = 64'h40; hwrite = 1'b1; hsize = 3'd2;
    @(posedge clk); #1;
    sel1 = 1'b0; htrans = 2'b00; hwdata = 32'hFFFF_0000;
    @(posedge clk); #1;
    chk("lit_wait_low", 64'({rdy1, resp1}), 64'({1'b0, 1'b0}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_ws3", 64'({rdy1, resp1, rd1}), 64'({1'b1, 1'b0, 32'h0}));
    chk("rst_async_ws0", 64'({rdy0, resp0, rd0}), 64'({1'b1, 1'b0, 32'h0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int d = 0; d < 2; d++) begin
      cur_rd[d]  = 32'h0;
      last_rd[d] = 32'h0;
    end
    q0.delete();
    q1.delete();
    chk_en = 1'b1;
    idle();
    xfer(1, 0, 3'd2, 64'h40, 32'h0);
    chk("lit_rst_no_write", 64'(rd1), 64'h0000_0000_1111_2222);
    idle();
    idle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
